vga_timing_decoder: RTL and testbench

Receive-side counterpart of the VGA timing generator. It samples a VGA-style pixel stream (active-low H/V sync plus 8-bit RGB) on the pixel clock and recovers pixel coordinates. It checks line and frame lengths against the configured format and emits a qualified pixel strobe with X/Y, for use by the cube-face colour sampler and the frame-capture logic.

---
 rtl/vga_pkg.sv | 25 ++
 rtl/vga_edge_sync.sv | 25 ++
 rtl/vga_timing_decoder.sv | 227 ++++++++++++++++++++++
 tb/tb_vga_timing_decoder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types and default 640x480 timing for the VGA timing decoder.
package vga_pkg;

    typedef enum logic [1:0] {
        HUNT,
        CHECK,
        LOCKED
    } vga_state_t;

    localparam int unsigned CNT_W = 10;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    localparam int DEF_H_TOTAL     = 800;
    localparam int DEF_V_TOTAL     = 525;
    localparam int DEF_X_START     = 144;
    localparam int DEF_Y_START     = 35;
    localparam int DEF_H_ACT       = 640;
    localparam int DEF_V_ACT       = 480;
    localparam int DEF_LOCK_FRAMES = 2;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/vga_edge_sync.sv
// Registers an active-low sync input and flags its falling edge
// (previous sample high, current sample low).
module vga_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic sync_in,
    output logic fall
);

    logic sync_s;
    logic sync_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_s <= 1'b0;
            sync_d <= 1'b0;
        end else begin
            sync_s <= sync_in;
            sync_d <= sync_s;
        end
    end

    assign fall = sync_d & ~sync_s;

endmodule

// File: rtl/vga_timing_decoder.sv
// Recovers pixel coordinates from a sampled VGA stream and locks onto the format.
// Define VGA_DECODER_STATS_EN to add the line/frame length and error-count outputs.
module vga_timing_decoder
    import vga_pkg::*;
#(
    parameter int H_TOTAL     = DEF_H_TOTAL,
    parameter int V_TOTAL     = DEF_V_TOTAL,
    parameter int X_START     = DEF_X_START,
    parameter int Y_START     = DEF_Y_START,
    parameter int H_ACT       = DEF_H_ACT,
    parameter int V_ACT       = DEF_V_ACT,
    parameter int LOCK_FRAMES = DEF_LOCK_FRAMES
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iVGA_H_SYNC,
    input  logic       iVGA_V_SYNC,
    input  logic [7:0] iVGA_R,
    input  logic [7:0] iVGA_G,
    input  logic [7:0] iVGA_B,
    output logic       oValid,
    output logic [9:0] oX,
    output logic [9:0] oY,
    output logic [7:0] oR,
    output logic [7:0] oG,
    output logic [7:0] oB,
    output logic       oFrame_Start,
    output logic       oLocked
`ifdef VGA_DECODER_STATS_EN
    ,
    output logic [9:0] oLine_Len,
    output logic [9:0] oFrame_Lines,
    output logic [7:0] oErr_Cnt
`endif
);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] X_LO   = CNT_W'(X_START);
    localparam logic [CNT_W-1:0] X_HI   = CNT_W'(X_START + H_ACT);
    localparam logic [CNT_W-1:0] Y_LO   = CNT_W'(Y_START);
    localparam logic [CNT_W-1:0] Y_HI   = CNT_W'(Y_START + V_ACT);

    logic             h_edge;
    logic             v_edge;
    logic [7:0]       s_r, s_g, s_b;

    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic [CNT_W-1:0] h_pos, v_pos;
    logic             v_arm;
    logic             lines_ok;
    logic [3:0]       good_cnt;

    logic             frame_start;
    logic             checking;
    logic             line_short;
    logic             h_sat;
    logic             v_sat;
    logic             line_bad;
    logic             frame_bad;
    logic             frame_good;

    vga_state_t       state, state_next;
    logic             in_win;
    logic             pix_en;

    vga_edge_sync u_h_edge (
        .clk     (iCLK),
        .rst     (iRST),
        .sync_in (iVGA_H_SYNC),
        .fall    (h_edge)
    );

    vga_edge_sync u_v_edge (
        .clk     (iCLK),
        .rst     (iRST),
        .sync_in (iVGA_V_SYNC),
        .fall    (v_edge)
    );

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            s_r <= '0;
            s_g <= '0;
            s_b <= '0;
        end else begin
            s_r <= iVGA_R;
            s_g <= iVGA_G;
            s_b <= iVGA_B;
        end
    end

    // h_pos/v_pos are the coordinates of the sample now in the input register;
    // h_cnt/v_cnt hold those of the previous sample, so at an H edge they still
    // carry the length of the line/frame that just ended.
    always_comb begin
        frame_start = h_edge && (v_arm || v_edge);
        h_pos       = h_edge ? '0 : sat_inc(h_cnt);
        v_pos       = v_cnt;
        if (frame_start) begin
            v_pos = '0;
        end else if (h_edge) begin
            v_pos = sat_inc(v_cnt);
        end
    end

    always_comb begin
        checking   = (state != HUNT);
        line_short = h_edge && (h_cnt != H_LAST);
        h_sat      = (h_pos == CNT_MAX) && (h_cnt != CNT_MAX);
        v_sat      = h_edge && !frame_start && (v_pos == CNT_MAX) && (v_cnt != CNT_MAX);
        line_bad   = checking && (line_short || h_sat);
        frame_bad  = checking && (v_sat ||
                     (frame_start && ((v_cnt != V_LAST) || !lines_ok || line_short)));
        frame_good = checking && frame_start && !frame_bad && !line_bad;
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            h_cnt    <= '0;
            v_cnt    <= '0;
            v_arm    <= 1'b0;
            lines_ok <= 1'b0;
            good_cnt <= '0;
        end else begin
            h_cnt <= h_pos;
            v_cnt <= v_pos;
            if (frame_start) begin
                v_arm <= 1'b0;
            end else if (v_edge) begin
                v_arm <= 1'b1;
            end
            if (frame_start) begin
                lines_ok <= 1'b1;
            end else if (line_bad) begin
                lines_ok <= 1'b0;
            end
            if (state == HUNT && frame_start) begin
                good_cnt <= '0;
            end else if (state == CHECK && frame_good) begin
                good_cnt <= good_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state <= HUNT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            HUNT: begin
                if (frame_start) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                if (line_bad || frame_bad) begin
                    state_next = HUNT;
                end else if (frame_good &&
                             (({1'b0, good_cnt} + 5'd1) >= 5'(LOCK_FRAMES))) begin
                    state_next = LOCKED;
                end
            end
            LOCKED: begin
                if (line_bad || frame_bad) begin
                    state_next = HUNT;
                end
            end
            default: state_next = HUNT;
        endcase
    end

    // Gating on the next state suppresses the pixel that would otherwise land
    // in the output register in the same cycle the lock is lost.
    always_comb begin
        in_win  = (h_pos >= X_LO) && (h_pos < X_HI) && (v_pos >= Y_LO) && (v_pos < Y_HI);
        pix_en  = (state_next == LOCKED) && in_win;
        oLocked = (state == LOCKED);
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oValid       <= 1'b0;
            oX           <= '0;
            oY           <= '0;
            oR           <= '0;
            oG           <= '0;
            oB           <= '0;
            oFrame_Start <= 1'b0;
        end else begin
            oValid       <= pix_en;
            oX           <= pix_en ? h_pos - X_LO : '0;
            oY           <= pix_en ? v_pos - Y_LO : '0;
            oR           <= pix_en ? s_r : '0;
            oG           <= pix_en ? s_g : '0;
            oB           <= pix_en ? s_b : '0;
            oFrame_Start <= pix_en && (h_pos == X_LO) && (v_pos == Y_LO);
        end
    end

`ifdef VGA_DECODER_STATS_EN
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oLine_Len    <= '0;
            oFrame_Lines <= '0;
            oErr_Cnt     <= '0;
        end else begin
            if (h_edge) begin
                oLine_Len <= h_cnt + 1'b1;
            end
            if (frame_start) begin
                oFrame_Lines <= v_cnt + 1'b1;
            end
            if ((line_bad || frame_bad) && (oErr_Cnt != 8'hFF)) begin
                oErr_Cnt <= oErr_Cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_decoder.sv
// Directed bench for vga_timing_decoder on a reduced 20x12 format.
module tb_vga_timing_decoder;

    localparam int H_T  = 20;
    localparam int V_T  = 12;
    localparam int XS   = 6;
    localparam int YS   = 3;
    localparam int HA   = 10;
    localparam int VA   = 6;
    localparam int HS_W = 2;

    logic       iCLK = 1'b0;
    logic       iRST;
    logic       iVGA_H_SYNC, iVGA_V_SYNC;
    logic [7:0] iVGA_R, iVGA_G, iVGA_B;
    logic       oValid, oFrame_Start, oLocked;
    logic [9:0] oX, oY;
    logic [7:0] oR, oG, oB;
`ifdef VGA_DECODER_STATS_EN
    logic [9:0] oLine_Len, oFrame_Lines;
    logic [7:0] oErr_Cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // one-sample-deep expectation pipeline
    bit         pend = 0;
    bit         p_valid, p_fs, p_locked;
    logic [9:0] p_x, p_y;
    logic [7:0] p_r, p_g, p_b;
    int         p_h, p_v;
    bit         probe_on = 0;
    int         pix_err;
    int         pulse_cnt;

    vga_timing_decoder #(
        .H_TOTAL     (H_T),
        .V_TOTAL     (V_T),
        .X_START     (XS),
        .Y_START     (YS),
        .H_ACT       (HA),
        .V_ACT       (VA),
        .LOCK_FRAMES (2)
    ) dut (
        .iCLK         (iCLK),
        .iRST         (iRST),
        .iVGA_H_SYNC  (iVGA_H_SYNC),
        .iVGA_V_SYNC  (iVGA_V_SYNC),
        .iVGA_R       (iVGA_R),
        .iVGA_G       (iVGA_G),
        .iVGA_B       (iVGA_B),
        .oValid       (oValid),
        .oX           (oX),
        .oY           (oY),
        .oR           (oR),
        .oG           (oG),
        .oB           (oB),
        .oFrame_Start (oFrame_Start),
        .oLocked      (oLocked)
`ifdef VGA_DECODER_STATS_EN
        ,
        .oLine_Len    (oLine_Len),
        .oFrame_Lines (oFrame_Lines),
        .oErr_Cnt     (oErr_Cnt)
`endif
    );

    always #5 iCLK = ~iCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one sample, clock it, compare outputs with the previous sample's expectation.
    task automatic step(input logic hs, input logic vs, input logic [7:0] r, input logic [7:0] g,
                        input logic [7:0] b, input bit lk, input int h, input int v);
        bit win;
        iVGA_H_SYNC = hs;
        iVGA_V_SYNC = vs;
        iVGA_R      = r;
        iVGA_G      = g;
        iVGA_B      = b;
        @(posedge iCLK);
        #1;
        if (pend) begin
            if (oValid !== p_valid || oX !== p_x || oY !== p_y || oR !== p_r || oG !== p_g ||
                oB !== p_b || oFrame_Start !== p_fs || oLocked !== p_locked) begin
                pix_err++;
                if (pix_err == 1)
                    $display("note: first pixel difference at h=%0d v=%0d: valid=%0b x=%0d y=%0d locked=%0b",
                             p_h, p_v, oValid, oX, oY, oLocked);
            end
            if (oValid === 1'b1) pulse_cnt++;
            if (probe_on && p_h == XS && p_v == YS) begin
                check("probe_r", oR, 8'hA5);
                check("probe_x", oX, 0);
                check("probe_y", oY, 0);
                check("probe_fs", oFrame_Start, 1);
            end
        end
        if (probe_on && h == XS && v == YS) check("probe_lat1", oR, 0);
        win      = (h >= XS) && (h < XS + HA) && (v >= YS) && (v < YS + VA);
        p_valid  = lk && win;
        p_x      = p_valid ? 10'(h - XS) : '0;
        p_y      = p_valid ? 10'(v - YS) : '0;
        p_r      = p_valid ? r : '0;
        p_g      = p_valid ? g : '0;
        p_b      = p_valid ? b : '0;
        p_fs     = p_valid && h == XS && v == YS;
        p_locked = lk;
        p_h      = h;
        p_v      = v;
        pend     = 1;
    endtask

    task automatic idle(input int n, input string tag);
        pix_err   = 0;
        pulse_cnt = 0;
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, -1, -1);
        check({tag, "_pix"}, pix_err, 0);
        check({tag, "_pulses"}, pulse_cnt, 0);
    endtask

    // lk: lock expected from the frame's first sample; short_line: line one clock short;
    // early_vs: pixel of the last line where V sync falls ahead of the next frame.
    task automatic run_frame(input int fnum, input bit lk, input int short_line, input int early_vs,
                             input int n_max, input int exp_pulses, input bit probe);
        bit   lk_cur;
        bit   stop;
        int   sent;
        int   len;
        logic hs, vs;
        logic [7:0] r;
        string tag;
        tag       = $sformatf("f%0d", fnum);
        lk_cur    = lk;
        stop      = 0;
        sent      = 0;
        probe_on  = probe;
        pix_err   = 0;
        pulse_cnt = 0;
        for (int v = 0; v < V_T && !stop; v++) begin
            len = (v == short_line) ? H_T - 1 : H_T;
            for (int h = 0; h < len && !stop; h++) begin
                if (n_max >= 0 && sent == n_max) begin
                    stop = 1;
                end else begin
                    if (short_line >= 0 && v == short_line + 1 && h == 0) lk_cur = 0;
                    hs = (h < HS_W) ? 1'b0 : 1'b1;
                    vs = (v == 0 || (early_vs >= 0 && v == V_T - 1 && h >= early_vs)) ? 1'b0 : 1'b1;
                    r  = (h == XS && v == YS) ? 8'hA5 : 8'(h * 3 + v);
                    step(hs, vs, r, 8'(v * 17 + fnum), 8'(h ^ (v << 2)), lk_cur, h, v);
                    sent++;
                    if (short_line >= 0 && v == short_line + 1 && h == 0)
                        check({tag, "_drop_before"}, oLocked, 1);
                    if (short_line >= 0 && v == short_line + 1 && h == 1) begin
                        check({tag, "_drop_locked"}, oLocked, 0);
                        check({tag, "_drop_valid"}, oValid, 0);
                    end
                end
            end
        end
        probe_on = 0;
        check({tag, "_pix"}, pix_err, 0);
        check({tag, "_pulses"}, pulse_cnt, exp_pulses);
    endtask

    initial begin
        iRST        = 1'b1;
        iVGA_H_SYNC = 1'b1;
        iVGA_V_SYNC = 1'b1;
        iVGA_R      = 8'h00;
        iVGA_G      = 8'h00;
        iVGA_B      = 8'h00;
        #1;
        check("rst_valid", oValid, 0);
        check("rst_locked", oLocked, 0);
        check("rst_x", oX, 0);
        check("rst_r", oR, 0);
        check("rst_fs", oFrame_Start, 0);
        @(posedge iCLK);
        @(posedge iCLK);
        #1;
        iRST = 1'b0;

        // no H edges at all: counter saturates, nothing locks
        idle(2000, "sat");
        check("sat_hcnt", 32'(dut.h_cnt), 1023);
        check("sat_locked", oLocked, 0);

        run_frame(1, 0, -1, -1, -1, 0, 0);
        run_frame(2, 0, -1, -1, -1, 0, 0);
        check("lock_before_3rd", oLocked, 0);
        run_frame(3, 1, -1, -1, -1, HA * VA, 1);
        check("lock_after_3rd", oLocked, 1);

        // V edge ahead of the H edge: frame starts at the following H edge
        run_frame(4, 1, -1, 10, -1, HA * VA, 0);
        run_frame(5, 1, -1, -1, -1, HA * VA, 0);
        check("armed_frame_locked", oLocked, 1);

        // one short line inside the active region
        run_frame(6, 1, 5, -1, -1, 3 * HA, 0);
        run_frame(7, 0, -1, -1, -1, 0, 0);
        run_frame(8, 0, -1, -1, -1, 0, 0);
        run_frame(9, 1, -1, -1, -1, HA * VA, 0);
        check("relock", oLocked, 1);
`ifdef VGA_DECODER_STATS_EN
        check("stats_err", oErr_Cnt, 1);
        check("stats_line", oLine_Len, H_T);
        check("stats_frame", oFrame_Lines, V_T);
`endif

        // asynchronous reset in the middle of an active line
        run_frame(10, 1, -1, -1, 110, 23, 0);
        check("pre_rst_valid", oValid, 1);
        #2;
        iRST = 1'b1;
        #1;
        check("mid_rst_valid", oValid, 0);
        check("mid_rst_locked", oLocked, 0);
        check("mid_rst_x", oX, 0);
        check("mid_rst_y", oY, 0);
        check("mid_rst_g", oG, 0);
        pend = 0;
        @(posedge iCLK);
        @(posedge iCLK);
        #1;
        iRST = 1'b0;
        idle(5, "post_rst");
        run_frame(11, 0, -1, -1, -1, 0, 0);
        run_frame(12, 0, -1, -1, -1, 0, 0);
        run_frame(13, 1, -1, -1, -1, HA * VA, 0);
        check("post_rst_locked", oLocked, 1);
`ifdef VGA_DECODER_STATS_EN
        check("post_rst_err", oErr_Cnt, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
